midi_note_ctrl: RTL and testbench
=================================

# midi_note_ctrl

Receives the raw MIDI serial stream on `midi_in` and turns note messages into the setpoint/enable pairs that drive the two floppy stepper channels. It sits directly upstream of the two `floppy` instances, in place of the SPI register path. The block has an internal UART receiver and a running-status MIDI parser. Each drive is monophonic and tracks one MIDI channel.

## Interface
- `CLK_RATE`, 50000000, clk frequency in Hz
- `BAUD`, 31250, MIDI bit rate
- `CH0`, 0, MIDI channel (0-15) assigned to drive 0
- `CH1`, 1, MIDI channel (0-15) assigned to drive 1
- `clk`  in  1  single system clock; all logic rising-edge
- `rst_n`  in  1  reset; asynchronous assert, active-low, applied to every flop
- `midi_in`  in  1  raw MIDI serial line; idle high; asynchronous to `clk`
- `f0_sp`  out  22  drive 0 setpoint, in clk cycles between step toggles
- `f0_en`  out  1  drive 0 enable
- `f1_sp`  out  22  drive 1 setpoint
- `f1_en`  out  1  drive 1 enable
- `note_evt`  out  1  one-cycle pulse when any `fN_en` or `fN_sp` changes
- `frame_err`  out  1  one-cycle pulse when a byte is dropped because its stop bit is low

## Operation
**Reset values:** `f0_sp`, `f1_sp`, `f0_en`, `f1_en`, `note_evt` and `frame_err` are all 0. The parser is in IDLE with running status cleared.

**UART receiver**
- Synchronise `midi_in` with a 2-flop synchroniser. Define BIT = `CLK_RATE`/`BAUD` (1600 at the defaults).
- IDLE → START on a falling edge of the synchronised input.
- In START, sample at BIT/2. If the line is high, it is a false start: return to IDLE.
- DATA samples 8 bits LSB-first, one every BIT cycles. STOP samples once more after another BIT.
- If the stop sample is 1, pulse `rx_valid` with the byte.
- If the stop sample is 0, pulse `frame_err`, emit no byte, and clear parser running status.

**Parser** (states IDLE, DATA1, DATA2)
- **Realtime bytes (0xF8-0xFF):** ignored completely, including in the middle of a message. State and running status are unchanged.
- **System bytes (0xF0-0xF7):** clear running status and go to IDLE.
- **Channel status bytes (0x80-0xEF):** latch running status and go to DATA1.
- **Data byte (<0x80) in IDLE:**
  - With running status set, treat it as the first data byte and proceed as in DATA1.
  - Otherwise discard it.
- **Message lengths:**
  - 0xC/0xD messages complete after 1 data byte.
  - 0x8/0x9/0xA/0xB/0xE messages complete after 2 data bytes.
  - After completion, return to IDLE with running status retained.
- **Completed message handling** (only when the channel equals `CHn`; all other messages are consumed silently):
  - **Note-on** (0x9, velocity > 0) with note in 24..71: set `fN_sp` = `PERIOD[note]`, set `fN_en` = 1, and record `cur_note[N]`. This uses last-note priority: a new note retargets a drive that is already playing.
  - **Note-on with note outside 24..71:** ignored.
  - **Note-off** (0x8, or 0x9 with velocity 0):
    - If the note equals `cur_note[N]` and `fN_en` = 1, set `fN_en` = 0. `fN_sp` holds its value.
    - Otherwise ignored.
  - **Control change 0xB with controller 120 or 123:** set `fN_en` = 0.
- **Both drives:** if `CH0` == `CH1`, both drives respond identically.
- **`note_evt`:** pulses only when an output value actually changes.

**Period table**
- `PERIOD[n] = round(CLK_RATE / (2 * 440 * 2^((n-69)/12)))`.
- At 50 MHz: n=57 → 113636, n=69 → 56818, n=24 → 764451. All entries fit in 22 bits.

## Timing
- A byte is delivered as `rx_valid` 1 cycle after the stop-bit sample.
- Outputs and `note_evt` update 1 cycle after that: 2 cycles after the stop sample.
- `frame_err` pulses 1 cycle after a bad stop sample.
- The receiver re-arms on the first high-to-low edge seen after the stop sample. Back-to-back bytes with no idle time are supported.
- If `rst_n` is asserted mid-byte or mid-message, everything returns to reset values immediately. The first byte after release is decoded only from a fresh start edge.
- There is no backpressure. At most one byte is in flight, so there are no simultaneous-event cases beyond realtime interleave.

## Structure
- **Package `midi_pkg`:**
  - status-nibble constants (NOTE_OFF=0x8, NOTE_ON=0x9, CC=0xB, PROG=0xC, CHPR=0xD);
  - NOTE_MIN=24 and NOTE_MAX=71;
  - constant function `period_of(note, clk_rate)` returning 22 bits, used to build the 48-entry ROM at elaboration.
- **Sub-module `midi_uart_rx`:** parameters `CLK_RATE` and `BAUD`. Ports: `clk`, `rst_n`, `rx`, `data[7:0]`, `valid`, `frame_err`.
- **Top file:** holds the parser FSM and the per-drive output registers.

## Test plan
- **Basic note on/off:** 0x90 0x45 0x64 → `f0_sp`=56818, `f0_en`=1, one `note_evt`, 2 clks after the stop sample. Then 0x80 0x45 0x00 → `f0_en`=0, `f0_sp` stays 56818.
- **Running status and realtime interleave:** 0x91 0x39 0x40, then 0x39 0xF8 0x00 → `f1_en`=1, `f1_sp`=113636, then `f1_en`=0. Drive 0 unchanged; the 0xF8 has no effect.
- **Retarget and stale note-off:** ch0 note-on 57 then note-on 69 → `f0_sp`=56818. Then note-off 57 → `f0_en` stays 1. Then note-off 69 → `f0_en`=0.
- **Filtering:** note-on for note 23 or 72, or on channel 5 → no output change and no `note_evt`. CC 0xB0 0x7B 0x00 while playing → `f0_en`=0.
- **Framing error:** a byte with the stop bit low → `frame_err` pulse and running status cleared. A following bare 0x45 0x64 is ignored.
- **Reset and glitch:** `rst_n` low mid-byte → all outputs 0 in the same cycle, and a correct decode after release. A 400-cycle low glitch on `midi_in` → false start, no byte.

Source files
------------

// File: rtl/midi_pkg.sv
// midi_pkg: MIDI status constants, playable note range and the note-to-period builder
package midi_pkg;
  localparam logic [3:0] NOTE_OFF = 4'h8, NOTE_ON = 4'h9, CC = 4'hB, PROG = 4'hC, CHPR = 4'hD;
  localparam logic [6:0] NOTE_MIN = 7'd24, NOTE_MAX = 7'd71;
  localparam int NOTES = 48;

  function automatic longint semi(input int k);
    case (k)
      0: return 64'd1000000000;
      1: return 64'd1059463094;
      2: return 64'd1122462048;
      3: return 64'd1189207115;
      4: return 64'd1259921050;
      5: return 64'd1334839854;
      6: return 64'd1414213562;
      7: return 64'd1498307077;
      8: return 64'd1587401052;
      9: return 64'd1681792831;
      10: return 64'd1781797436;
      default: return 64'd1887748625;
    endcase
  endfunction

  // Half-period of note n, split into octaves (shift) and semitones (2^(k/12) scaled by 1e9).
  function automatic logic [21:0] period_of(input int note, input longint clk_rate);
    int d, o;
    longint num, den;
    d = 69 - note;
    o = d >= 0 ? d / 12 : -1;
    num = clk_rate * semi(d - 12 * o);
    den = longint'(880) * 64'd1000000000;
    num = o >= 0 ? num << o : num;
    den = o >= 0 ? den : den * 2;
    return 22'((num + den / 2) / den);
  endfunction
endpackage

// File: rtl/midi_uart_rx.sv
// midi_uart_rx: 8N1 receiver with synchroniser, false-start rejection and stop-bit check
module midi_uart_rx #(
  parameter int CLK_RATE = 50000000,
  parameter int BAUD = 31250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);
  localparam int BIT = CLK_RATE / BAUD;
  localparam int W = $clog2(BIT);
  localparam logic [W-1:0] HALF = W'(BIT / 2 - 1);
  localparam logic [W-1:0] LAST = W'(BIT - 1);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  logic [1:0] sync_q, state_q, state_d;
  logic prev_q, valid_q, valid_d, err_q, err_d, s, tick;
  logic [W-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d;
  assign s = sync_q[1];
  assign tick = cnt_q == (state_q == START ? HALF : LAST);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    sh_d = sh_q;
    valid_d = 1'b0;
    err_d = 1'b0;
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (prev_q & ~s) state_d = START;
      end
      START: if (tick) begin
        state_d = s ? IDLE : DATA;
        idx_d = '0;
      end
      DATA: if (tick) begin
        sh_d = {s, sh_q[7:1]};
        idx_d = idx_q + 1'b1;
        if (&idx_q) state_d = STOP;
      end
      default: if (tick) begin
        state_d = IDLE;
        valid_d = s;
        err_d = ~s;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx};
      prev_q <= s;
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
  end
  assign data = sh_q;
  assign valid = valid_q;
  assign frame_err = err_q;
endmodule

// File: rtl/midi_note_ctrl.sv
// midi_note_ctrl: MIDI byte stream to per-drive floppy setpoint/enable with running status
module midi_note_ctrl
  import midi_pkg::*;
#(
  parameter int CLK_RATE = 50000000,
  parameter int BAUD = 31250,
  parameter int CH0 = 0,
  parameter int CH1 = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        midi_in,
  output logic [21:0] f0_sp,
  output logic        f0_en,
  output logic [21:0] f1_sp,
  output logic        f1_en,
  output logic        note_evt,
  output logic        frame_err
);
  localparam logic [1:0] IDLE = 2'd0, DATA1 = 2'd1, DATA2 = 2'd2;
  logic [7:0] rx_data, st_q, st_d;
  logic rx_valid, rx_err, run_q, run_d, done, evt_q, evt_d, on, off, mute, in_rng;
  logic [1:0] state_q, state_d, en_q, en_d;
  logic [6:0] d1_q, d1_d, vel;
  logic [1:0][21:0] sp_q, sp_d;
  logic [1:0][6:0] cur_q, cur_d;
  logic [1:0][3:0] chn;
  logic [21:0] rom [NOTES];

  midi_uart_rx #(.CLK_RATE(CLK_RATE), .BAUD(BAUD)) u_rx (
    .clk(clk), .rst_n(rst_n), .rx(midi_in), .data(rx_data), .valid(rx_valid), .frame_err(rx_err)
  );

  for (genvar i = 0; i < NOTES; i++) begin : g_rom
    assign rom[i] = period_of(int'(NOTE_MIN) + i, longint'(CLK_RATE));
  end

  assign chn = {4'(CH1), 4'(CH0)};
  assign vel = rx_data[6:0];
  assign on = st_q[7:4] == NOTE_ON && vel != 7'd0;
  assign off = st_q[7:4] == NOTE_OFF || (st_q[7:4] == NOTE_ON && vel == 7'd0);
  assign mute = st_q[7:4] == CC && (d1_q == 7'd120 || d1_q == 7'd123);
  assign in_rng = d1_q >= NOTE_MIN && d1_q <= NOTE_MAX;

  // Parser runs only on data bytes while running status is held; non-IDLE implies run_q.
  always_comb begin
    state_d = state_q;
    run_d = run_q;
    st_d = st_q;
    d1_d = d1_q;
    done = 1'b0;
    if (rx_err) begin
      state_d = IDLE;
      run_d = 1'b0;
    end else if (rx_valid && rx_data < 8'hF8) begin
      if (rx_data >= 8'hF0) begin
        state_d = IDLE;
        run_d = 1'b0;
      end else if (rx_data[7]) begin
        st_d = rx_data;
        run_d = 1'b1;
        state_d = DATA1;
      end else if (state_q == DATA2) begin
        done = 1'b1;
        state_d = IDLE;
      end else if (run_q) begin
        d1_d = rx_data[6:0];
        done = st_q[7:4] == PROG || st_q[7:4] == CHPR;
        state_d = done ? IDLE : DATA2;
      end
    end
  end

  always_comb begin
    sp_d = sp_q;
    en_d = en_q;
    cur_d = cur_q;
    evt_d = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (done && st_q[3:0] == chn[i]) begin
        if (on && in_rng) begin
          sp_d[i] = rom[6'(d1_q - NOTE_MIN)];
          en_d[i] = 1'b1;
          cur_d[i] = d1_q;
        end else if ((off && d1_q == cur_q[i]) || mute) en_d[i] = 1'b0;
      end
      evt_d = evt_d | (sp_d[i] != sp_q[i]) | (en_d[i] != en_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      run_q <= 1'b0;
      st_q <= '0;
      d1_q <= '0;
      sp_q <= '0;
      en_q <= '0;
      cur_q <= '0;
      evt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q <= run_d;
      st_q <= st_d;
      d1_q <= d1_d;
      sp_q <= sp_d;
      en_q <= en_d;
      cur_q <= cur_d;
      evt_q <= evt_d;
    end
  end

  assign f0_sp = sp_q[0];
  assign f1_sp = sp_q[1];
  assign f0_en = en_q[0];
  assign f1_en = en_q[1];
  assign note_evt = evt_q;
  assign frame_err = rx_err;
endmodule

// File: tb/tb_midi_note_ctrl.sv
// tb_midi_note_ctrl: directed table, corner sequences and random MIDI bytes against a message-level model
module tb_midi_note_ctrl;
  localparam int BIT = 16;
  logic clk = 1'b0, rst_n = 1'b0, midi_in = 1'b1;
  logic [21:0] f0_sp, f1_sp;
  logic f0_en, f1_en, note_evt, frame_err;
  int checks = 0, errors = 0, evt_cnt = 0, ferr_cnt = 0;
  int rs, m_sp[2], m_en[2], m_cur[2], exp_evt = 0, exp_ferr = 0;
  int q[$];

  typedef struct {
    logic [7:0] b0, b1, b2;
    int sp0, en0, sp1, en1, evts;
  } vec_t;
  vec_t tbl[13];

  always #5 clk = ~clk;

  midi_note_ctrl #(.CLK_RATE(50000000), .BAUD(50000000 / BIT), .CH0(0), .CH1(1)) dut (
    .clk(clk), .rst_n(rst_n), .midi_in(midi_in), .f0_sp(f0_sp), .f0_en(f0_en),
    .f1_sp(f1_sp), .f1_en(f1_en), .note_evt(note_evt), .frame_err(frame_err)
  );

  always @(negedge clk) begin
    if (note_evt) evt_cnt++;
    if (frame_err) ferr_cnt++;
  end

  function automatic int exp_period(input int n);
    return $rtoi(50.0e6 / (880.0 * (2.0 ** ((n - 69) / 12.0))) + 0.5);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    rs = -1;
    q.delete();
    for (int i = 0; i < 2; i++) begin
      m_sp[i] = 0;
      m_en[i] = 0;
      m_cur[i] = 0;
    end
  endtask

  task automatic model_msg(input int st, input int d1, input int d2);
    bit chg = 0;
    for (int i = 0; i < 2; i++) begin
      if ((st & 15) != i) continue;
      if ((st >> 4) == 9 && d2 > 0) begin
        if (d1 >= 24 && d1 <= 71) begin
          if (!m_en[i] || m_sp[i] != exp_period(d1)) chg = 1;
          m_sp[i] = exp_period(d1);
          m_en[i] = 1;
          m_cur[i] = d1;
        end
      end else if ((st >> 4) == 8 || (st >> 4) == 9) begin
        if (d1 == m_cur[i] && m_en[i] != 0) begin
          chg = 1;
          m_en[i] = 0;
        end
      end else if ((st >> 4) == 11 && (d1 == 120 || d1 == 123)) begin
        if (m_en[i] != 0) chg = 1;
        m_en[i] = 0;
      end
    end
    if (chg) exp_evt++;
  endtask

  task automatic model_byte(input int b);
    int need;
    if (b >= 'hF8) return;
    if (b >= 'hF0) begin
      rs = -1;
      q.delete();
    end else if (b >= 'h80) begin
      rs = b;
      q.delete();
    end else if (rs >= 0) begin
      q.push_back(b);
      need = ((rs >> 4) == 12 || (rs >> 4) == 13) ? 1 : 2;
      if (q.size() == need) begin
        model_msg(rs, q[0], need == 2 ? q[1] : 0);
        q.delete();
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input bit stop = 1'b1);
    midi_in = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      midi_in = b[i];
      repeat (BIT) @(negedge clk);
    end
    midi_in = stop;
    repeat (BIT) @(negedge clk);
    if (!stop) begin
      midi_in = 1'b1;
      repeat (BIT) @(negedge clk);
      rs = -1;
      q.delete();
      exp_ferr++;
    end else model_byte(int'(b));
  endtask

  task automatic chk_model(input string tag);
    chk($sformatf("%s f0_sp", tag), f0_sp, m_sp[0]);
    chk($sformatf("%s f0_en", tag), f0_en, m_en[0]);
    chk($sformatf("%s f1_sp", tag), f1_sp, m_sp[1]);
    chk($sformatf("%s f1_en", tag), f1_en, m_en[1]);
    chk($sformatf("%s note_evt count", tag), evt_cnt, exp_evt);
    chk($sformatf("%s frame_err count", tag), ferr_cnt, exp_ferr);
  endtask

  initial begin
    int e0, r, ty[6], chs[4];
    logic [7:0] b;
    bit stop;
    tbl = '{
      '{8'h90, 8'h45, 8'h64, 56818, 1, 0, 0, 1},
      '{8'h80, 8'h45, 8'h00, 56818, 0, 0, 0, 1},
      '{8'h91, 8'h39, 8'h40, 56818, 0, 113636, 1, 1},
      '{8'h39, 8'hF8, 8'h00, 56818, 0, 113636, 0, 1},
      '{8'h90, 8'h39, 8'h40, 113636, 1, 113636, 0, 1},
      '{8'h90, 8'h45, 8'h40, 56818, 1, 113636, 0, 1},
      '{8'h80, 8'h39, 8'h00, 56818, 1, 113636, 0, 0},
      '{8'h80, 8'h45, 8'h00, 56818, 0, 113636, 0, 1},
      '{8'h90, 8'h17, 8'h40, 56818, 0, 113636, 0, 0},
      '{8'h90, 8'h48, 8'h40, 56818, 0, 113636, 0, 0},
      '{8'h95, 8'h45, 8'h40, 56818, 0, 113636, 0, 0},
      '{8'h90, 8'h18, 8'h40, 764451, 1, 113636, 0, 1},
      '{8'hB0, 8'h7B, 8'h00, 764451, 0, 113636, 0, 1}
    };
    ty = '{8, 9, 9, 11, 12, 14};
    chs = '{0, 1, 0, 5};
    model_reset();
    repeat (4) @(negedge clk);
    chk("reset f0_sp", f0_sp, 0);
    chk("reset f0_en", f0_en, 0);
    chk("reset f1_sp", f1_sp, 0);
    chk("reset f1_en", f1_en, 0);
    chk("reset note_evt", note_evt, 0);
    chk("reset frame_err", frame_err, 0);
    rst_n = 1'b1;
    repeat (BIT) @(negedge clk);

    foreach (tbl[i]) begin
      e0 = evt_cnt;
      send(tbl[i].b0);
      send(tbl[i].b1);
      send(tbl[i].b2);
      chk($sformatf("row%0d f0_sp", i), f0_sp, tbl[i].sp0);
      chk($sformatf("row%0d f0_en", i), f0_en, tbl[i].en0);
      chk($sformatf("row%0d f1_sp", i), f1_sp, tbl[i].sp1);
      chk($sformatf("row%0d f1_en", i), f1_en, tbl[i].en1);
      chk($sformatf("row%0d note_evt pulses", i), evt_cnt - e0, tbl[i].evts);
    end

    send(8'h90); send(8'h45); send(8'h64);
    send(8'h90); send(8'h45); send(8'h00);
    send(8'h3C, 1'b0);
    send(8'h45); send(8'h64);
    chk("framing f0_en after bare data", f0_en, 0);
    chk("framing pulses", ferr_cnt, 1);
    chk_model("framing");

    send(8'h90); send(8'h45); send(8'h64);
    midi_in = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset f0_en", f0_en, 0);
    chk("async reset f0_sp", f0_sp, 0);
    chk("async reset f1_sp", f1_sp, 0);
    midi_in = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (BIT) @(negedge clk);
    send(8'h90); send(8'h45); send(8'h64);
    chk("post reset f0_sp", f0_sp, 56818);
    chk_model("post reset");

    midi_in = 1'b0;
    repeat (4) @(negedge clk);
    midi_in = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    send(8'h90); send(8'h39); send(8'h64);
    chk("glitch then note f0_sp", f0_sp, 113636);
    chk_model("glitch");

    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 99);
      stop = 1'b1;
      if (r < 16) b = 8'((ty[$urandom_range(0, 5)] << 4) | chs[$urandom_range(0, 3)]);
      else if (r < 19) b = 8'(8'hF8 + $urandom_range(0, 7));
      else if (r < 21) b = 8'(8'hF0 + $urandom_range(0, 7));
      else if (r < 23) begin
        b = 8'($urandom_range(0, 255));
        stop = 1'b0;
      end else if (r < 28) b = 8'h00;
      else if (r < 33) b = $urandom_range(0, 1) != 0 ? 8'd120 : 8'd123;
      else b = 8'($urandom_range(20, 75));
      send(b, stop);
      chk_model($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
